// File: rtl/unary_expand450.sv
`default_nettype none
// ============================================================================
//  Module      : unary_expand450
//  Description : Streaming count-to-unary expander. Accepts a count N over a
//                valid/ready handshake and emits a LEN-bit thermometer vector
//                (bits [N-1:0] set) as NB consecutive W-bit beats.
//  Revision    : 1.0  initial release
// ============================================================================
module unary_expand450 #(
   parameter int LEN = 450,
   parameter int W   = 50,
   parameter int BW  = $clog2(LEN),
   parameter int NB  = (LEN + W - 1) / W,
   parameter int IW  = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] in_cnt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [IW-1:0] out_idx,
   output logic          out_last
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   localparam logic [BW-1:0] c_LEN  = BW'(LEN);
   localparam logic [IW-1:0] c_LAST = IW'(NB - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] b_q, b_d;
   logic [BW-1:0] cq_q, cq_d;
   logic          w_emit;

   // Handshake flags come from registered state; reset forces both low.
   assign w_emit    = (state_q == S_EMIT) && !rst;
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = w_emit;
   assign out_idx   = w_emit ? b_q : '0;
   assign out_last  = w_emit && (b_q == c_LAST);

   // Per-bit thermometer decode; the absolute bit position is formed in 32 bits
   // so it never wraps, and positions at or beyond LEN stay clear.
   for (genvar j = 0; j < W; j++) begin : g_bit
      logic [31:0] w_pos;
      assign w_pos       = 32'(b_q) * 32'(W) + 32'(j);
      assign out_data[j] = w_emit && (w_pos < 32'(cq_q)) && (w_pos < 32'(LEN));
   end

   // Next-state logic: accept a saturated count in IDLE, step beats in EMIT.
   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      cq_d    = cq_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               cq_d    = (in_cnt > c_LEN) ? c_LEN : in_cnt;
               b_d     = '0;
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (b_q == c_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  b_d = b_q + IW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset that abandons any vector in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         b_q     <= '0;
         cq_q    <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         cq_q    <= cq_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_unary_expand450.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_unary_expand450
//  Description : Directed self-checking bench for unary_expand450 at the
//                default geometry (W=50, NB=9) and a padded one (W=64, NB=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_unary_expand450;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, out_ready, sel_b;
   logic [8:0] in_cnt;

   logic        in_ready_a, out_valid_a, out_last_a;
   logic [49:0] out_data_a;
   logic [3:0]  out_idx_a;
   logic        in_ready_b, out_valid_b, out_last_b;
   logic [63:0] out_data_b;
   logic [2:0]  out_idx_b;

   logic        w_in_valid_a, w_in_valid_b;
   logic        obs_ready, obs_valid, obs_last;
   logic [63:0] obs_data;
   logic [3:0]  obs_idx;

   int n_cmp = 0;
   int n_err = 0;

   assign w_in_valid_a = in_valid && !sel_b;
   assign w_in_valid_b = in_valid &&  sel_b;
   assign obs_ready = sel_b ? in_ready_b  : in_ready_a;
   assign obs_valid = sel_b ? out_valid_b : out_valid_a;
   assign obs_last  = sel_b ? out_last_b  : out_last_a;
   assign obs_data  = sel_b ? out_data_b  : {14'd0, out_data_a};
   assign obs_idx   = sel_b ? {1'b0, out_idx_b} : out_idx_a;

   unary_expand450 u_dut_a (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid_a), .in_ready(in_ready_a), .in_cnt(in_cnt),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .out_idx(out_idx_a), .out_last(out_last_a)
   );

   unary_expand450 #(.W(64)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid_b), .in_ready(in_ready_b), .in_cnt(in_cnt),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .out_idx(out_idx_b), .out_last(out_last_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ones(input int n);
      return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
   endfunction

   // Outputs of the selected DUT while idle: nothing valid, everything zero.
   task automatic check_idle(input string tag, input logic exp_rdy);
      check({tag, "_in_ready"}, 64'(obs_ready), 64'(exp_rdy));
      check({tag, "_valid"},    64'(obs_valid), 64'd0);
      check({tag, "_data"},     obs_data,       64'd0);
      check({tag, "_idx"},      64'(obs_idx),   64'd0);
      check({tag, "_last"},     64'(obs_last),  64'd0);
   endtask

   // Send one count and collect a whole vector. Expected beats: nf full beats
   // of width bw, then one beat holding np ones, then zero beats.
   task automatic run_vec(input string tag, input int cnt, input int nf, input int np,
                          input int bw, input int nb, input int exp_pop,
                          input bit bp, input bit hold_v);
      int          k, cyc, pop;
      bit          have_prev, rdy;
      logic [63:0] prev_data, exp_data;
      logic [3:0]  prev_idx;
      logic        prev_last;
      @(negedge clk);
      check({tag, "_accept_rdy"}, 64'(obs_ready), 64'd1);
      in_cnt   = 9'(cnt);
      in_valid = 1'b1;
      @(negedge clk);
      if (!hold_v) in_valid = 1'b0;
      k = 0; cyc = 0; pop = 0; have_prev = 1'b0;
      prev_data = '0; prev_idx = '0; prev_last = 1'b0;
      while (k < nb && cyc < 200) begin
         check({tag, "_valid"},   64'(obs_valid), 64'd1);
         check({tag, "_busy_rdy"}, 64'(obs_ready), 64'd0);
         if (have_prev) begin
            check({tag, "_stall_data"}, obs_data,       prev_data);
            check({tag, "_stall_idx"},  64'(obs_idx),   64'(prev_idx));
            check({tag, "_stall_last"}, 64'(obs_last),  64'(prev_last));
         end
         exp_data = (k < nf) ? ones(bw) : ((k == nf) ? ones(np) : 64'd0);
         check({tag, "_data"}, obs_data,      exp_data);
         check({tag, "_idx"},  64'(obs_idx),  64'(k));
         check({tag, "_last"}, 64'(obs_last), 64'(k == nb - 1));
         rdy       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = rdy;
         if (rdy) begin
            pop += $countones(obs_data);
            k++;
            have_prev = 1'b0;
         end else begin
            have_prev = 1'b1;
            prev_data = obs_data;
            prev_idx  = obs_idx;
            prev_last = obs_last;
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, "_beats"}, 64'(k), 64'(nb));
      check({tag, "_popcount"}, 64'(pop), 64'(exp_pop));
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_idle({tag, "_after"}, 1'b1);
   endtask

   // Directed sequence.
   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel_b = 1'b0; in_cnt = '0;
      repeat (2) @(negedge clk);
      check_idle("reset_a", 1'b0);
      sel_b = 1'b1;
      check_idle("reset_b", 1'b0);
      sel_b = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_rdy", 64'(in_ready_a), 64'd1);

      run_vec("zero",  0,   0, 0,  50, 9, 0,   1'b0, 1'b0);
      run_vec("c123",  123, 2, 23, 50, 9, 123, 1'b0, 1'b0);
      run_vec("c450",  450, 9, 0,  50, 9, 450, 1'b0, 1'b0);
      run_vec("c500",  500, 9, 0,  50, 9, 450, 1'b0, 1'b0);
      run_vec("bp77",  77,  1, 27, 50, 9, 77,  1'b1, 1'b1);

      // Abandon a vector after beat 4 has transferred.
      @(negedge clk);
      in_cnt = 9'd450; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_idx5", 64'(out_idx_a), 64'd5);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 64'(out_valid_a), 64'd0);
      check("mid_rst_last",  64'(out_last_a),  64'd0);
      check("mid_rst_rdy",   64'(in_ready_a),  64'd0);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("mid_quiet_valid", 64'(out_valid_a), 64'd0);
         check("mid_quiet_last",  64'(out_last_a),  64'd0);
      end
      out_ready = 1'b0;
      run_vec("c1", 1, 0, 1, 50, 9, 1, 1'b0, 1'b0);

      // Padded geometry: 8 beats of 64 bits, 62 pad bits in the final beat.
      sel_b = 1'b1;
      run_vec("pad450", 450, 7, 2, 64, 8, 450, 1'b0, 1'b0);
      run_vec("pad449", 449, 7, 1, 64, 8, 449, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire

// File: doc/unary_expand450.md
# unary_expand450

Streaming count-to-unary expander that inverts the 450-bit population-count reduction. It accepts a count `N` over a valid/ready handshake. It then emits a 450-bit thermometer vector (bits `[N-1:0]` set, all others clear) as a sequence of `W`-bit beats. It sits at the boundary where activation/threshold counts are re-expanded into bit-vectors for the next binarized layer or a bit-serial consumer. Reassembling the emitted beats and popcounting them returns exactly the accepted (saturated) count.

## Interface
Parameters:
- `len`, 450, vector length in bits
- `W`, 50, beat width in bits
- `bW`, `$clog2(len)`, count width (9 at default)
- `NB`, `(len+W-1)/W`, beats per vector (derived; 9 at default)
- `iW`, `$clog2(NB)` (minimum 1), beat-index width

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  count available
- `in_ready`  out  1  block can accept a count
- `in_cnt`  in  bW  requested number of ones
- `out_valid`  out  1  beat available
- `out_ready`  in  1  consumer accepts beat
- `out_data`  out  W  beat payload; bit `j` is vector bit `idx*W+j`
- `out_idx`  out  iW  beat index, 0..NB-1
- `out_last`  out  1  high on beat NB-1 only

## Operation
- FSM states: `IDLE`, `EMIT`.
- **IDLE**
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid&&in_ready`: latch `cq = min(in_cnt, len)`, clear beat counter `b`, go to `EMIT`.
- **EMIT**
  - `in_ready=0`, `out_valid=1`, `out_idx=b`, `out_last=(b==NB-1)`.
  - `out_data[j] = ((b*W+j) < cq) && ((b*W+j) < len)`.
  - Bits beyond `len` in the final beat are always 0.
- **Beat transfer** on `out_valid&&out_ready`:
  - If `b<NB-1`: `b` increments.
  - If `b==NB-1`: go to `IDLE`.
- **Stall:** while `out_valid&&!out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
- **Saturation:** `in_cnt>len` (451..511) saturates to `len`. `in_cnt=0` still emits NB all-zero beats.
- **Comparison width:** `b*W+j` is computed at width `bW+1` or wider so it never wraps.
- **Inactive outputs:** when `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`.
- **Throughput:** no overlap of vectors. A new count is accepted only in `IDLE`.
- **Reset** (`rst` high at an edge):
  - State goes to `IDLE`, `b=0`, `cq=0`.
  - A partially emitted vector is abandoned. No further beats are emitted and no `out_last` is produced for it.
  - While `rst` is high, `in_ready=0` and `out_valid=0`.

## Timing
- Reset values: `in_ready=0` during reset, then 1 in the first cycle after reset deasserts. `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`.
- Latency: count accepted at edge t; beat 0 is valid in the cycle after edge t.
- With `out_ready` held high: NB consecutive beat cycles, then one `IDLE` cycle. The next count is accepted at the end of that cycle.
- Throughput: one vector per NB+1 cycles (10 at default).
- `in_ready` and `out_valid` are decoded from registered state only. There are no combinational paths from `in_valid` or `out_ready` to any output.
- `out_data` is a function of registered `b` and `cq` only.

## Test plan
- **Zero count:** `in_cnt=0`, `out_ready=1` → 9 beats of `out_data=0`, `out_idx` 0..8, `out_last` only on idx 8. `in_ready` returns to 1 in the cycle after the last beat.
- **Mid-beat boundary:** `in_cnt=123` → beats 0,1 = all ones; beat 2 = `0x7FFFFF` (23 ones); beats 3..8 = 0. Reassembled vector has popcount 123.
- **Full and saturated counts:** `in_cnt=450`, then `in_cnt=500` → both produce 9 all-ones beats. Reassembled popcount is 450 in both cases.
- **Backpressure:** `in_cnt=77` with `out_ready` toggled pseudo-randomly → payload stable across every stall. Exactly 9 transfers. `in_valid` held high throughout is ignored until `IDLE`.
- **Reset mid-stream:** `rst` pulsed after beat 4 transfers → next cycle `out_valid=0`, no `out_last` for that vector. The next count (`in_cnt=1`) yields beat 0 = `0x1`, all other beats 0.
- **Padding** (`W=64`, so NB=8):
  - `in_cnt=450` → beat 7 = `0x3`; bits 2..63 are 0.
  - `in_cnt=449` → beat 7 = `0x1`.
